// File: rtl/led_count_display.sv
// rtl/led_count_display.sv - prescaled 4-bit up/down counter driving a 7-segment digit and an LED bar
//
// Ports:
//   clk        board clock
//   rst        synchronous active-high reset
//   en         1: prescaler and state advance; 0: everything holds
//   direction  0: count/walk up, 1: count/walk down (also lights the decimal point)
//   mode       bar mode: 00 walk, 01 bounce, 10 fill, 11 blank
//   load       one-cycle strobe; loads load_val into count and load_val % BAR_WIDTH into pos
//   load_val   value to load
//   count      counter state register (no latency)
//   tick       combinational pulse on the cycle a step is taken
//   seg_out    registered segments {dp, g..a}
//   bar_out    registered LED bar, bit 0 = position 0
module led_count_display #(
    parameter int CLK_DIV    = 12_500_000,
    parameter int BAR_WIDTH  = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 direction,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [3:0]           load_val,
    output logic [3:0]           count,
    output logic                 tick,
    output logic [7:0]           seg_out,
    output logic [BAR_WIDTH-1:0] bar_out
);

    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int POS_W   = $clog2(BAR_WIDTH);

    localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(CLK_DIV - 1);
    localparam logic [PRESC_W-1:0]   PRESC_ONE = PRESC_W'(1);
    localparam logic [POS_W-1:0]     POS_MAX   = POS_W'(BAR_WIDTH - 1);
    localparam logic [POS_W-1:0]     POS_ONE   = POS_W'(1);
    // XOR masks that turn the active-high images into pin polarity
    localparam logic [7:0]           SEG_INV   = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [BAR_WIDTH-1:0] BAR_INV   = (ACTIVE_LOW != 0) ? {BAR_WIDTH{1'b1}} : {BAR_WIDTH{1'b0}};

    logic [PRESC_W-1:0]   presc;
    logic [POS_W-1:0]     pos;
    logic                 bdir;
    logic [POS_W-1:0]     pos_next;
    logic                 bdir_next;
    logic [POS_W-1:0]     load_pos;
    logic [6:0]           seg_hex;
    logic [BAR_WIDTH-1:0] bar_hi;

    assign tick     = en & (presc == PRESC_MAX);
    assign load_pos = POS_W'({28'd0, load_val} % BAR_WIDTH);

    // Bar position after a step. Bounce reflects off the ends using its own
    // direction flag; every other mode follows the direction input and wraps.
    always_comb begin
        pos_next  = pos;
        bdir_next = bdir;
        if (mode == 2'b01) begin
            if (!bdir) begin
                if (pos == POS_MAX) begin
                    pos_next  = pos - POS_ONE;
                    bdir_next = 1'b1;
                end else begin
                    pos_next = pos + POS_ONE;
                end
            end else begin
                if (pos == '0) begin
                    pos_next  = POS_ONE;
                    bdir_next = 1'b0;
                end else begin
                    pos_next = pos - POS_ONE;
                end
            end
        end else if (!direction) begin
            pos_next = (pos == POS_MAX) ? '0 : pos + POS_ONE;
        end else begin
            pos_next = (pos == '0) ? POS_MAX : pos - POS_ONE;
        end
    end

    // Active-high hex decode, bits {g,f,e,d,c,b,a}
    always_comb begin
        seg_hex = 7'h00;
        case (count)
            4'h0: seg_hex = 7'h3F;
            4'h1: seg_hex = 7'h06;
            4'h2: seg_hex = 7'h5B;
            4'h3: seg_hex = 7'h4F;
            4'h4: seg_hex = 7'h66;
            4'h5: seg_hex = 7'h6D;
            4'h6: seg_hex = 7'h7D;
            4'h7: seg_hex = 7'h07;
            4'h8: seg_hex = 7'h7F;
            4'h9: seg_hex = 7'h6F;
            4'hA: seg_hex = 7'h77;
            4'hB: seg_hex = 7'h7C;
            4'hC: seg_hex = 7'h39;
            4'hD: seg_hex = 7'h5E;
            4'hE: seg_hex = 7'h79;
            4'hF: seg_hex = 7'h71;
            default: seg_hex = 7'h00;
        endcase
    end

    // Active-high bar image: one-hot for walk/bounce, thermometer for fill
    always_comb begin
        bar_hi = '0;
        for (int i = 0; i < BAR_WIDTH; i++) begin
            case (mode)
                2'b00, 2'b01: bar_hi[i] = (i == int'(pos));
                2'b10:        bar_hi[i] = (i <= int'(pos));
                default:      bar_hi[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            count   <= 4'd0;
            pos     <= '0;
            bdir    <= 1'b0;
            seg_out <= 8'h3F ^ SEG_INV;
            bar_out <= BAR_INV;
        end else begin
            // A load restarts the prescaler and suppresses the step even if tick is high
            if (load) begin
                presc <= '0;
                count <= load_val;
                pos   <= load_pos;
                bdir  <= 1'b0;
            end else if (en) begin
                presc <= tick ? '0 : presc + PRESC_ONE;
                if (tick) begin
                    count <= direction ? count - 4'd1 : count + 4'd1;
                    pos   <= pos_next;
                    bdir  <= bdir_next;
                end
            end
            seg_out <= {direction, seg_hex} ^ SEG_INV;
            bar_out <= bar_hi ^ BAR_INV;
        end
    end

endmodule

// File: tb/tb_led_count_display.sv
// tb/tb_led_count_display.sv - scoreboard bench for led_count_display (CLK_DIV=4, BAR_WIDTH=8, ACTIVE_LOW=1)
module tb_led_count_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       direction;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tick;
    logic [7:0] seg_out;
    logic [7:0] bar_out;

    int n_checks = 0;
    int n_fail   = 0;

    led_count_display #(
        .CLK_DIV   (4),
        .BAR_WIDTH (8),
        .ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .direction(direction),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tick     (tick),
        .seg_out  (seg_out),
        .bar_out  (bar_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model and scoreboard
    typedef struct packed {
        logic [3:0] c;
        logic [7:0] s;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int         m_presc = 0;
    logic [3:0] m_count = 4'd0;
    int         m_pos   = 0;
    bit         m_bdir  = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        bit   t;
        t = en && (m_presc == 3);
        if (rst) begin
            m_presc = 0;
            m_count = 4'd0;
            m_pos   = 0;
            m_bdir  = 1'b0;
            e.s     = 8'hC0;
            e.b     = 8'hFF;
        end else begin
            e.s = ~{direction, hex_tbl[m_count]};
            case (mode)
                2'd0, 2'd1: e.b = ~(8'd1 << m_pos);
                2'd2:       e.b = 8'(~((9'd2 << m_pos) - 9'd1));
                default:    e.b = 8'hFF;
            endcase
            if (load) begin
                m_count = load_val;
                m_pos   = int'(load_val) % 8;
                m_bdir  = 1'b0;
                m_presc = 0;
            end else if (en) begin
                m_presc = (m_presc + 1) % 4;
                if (t) begin
                    m_count = direction ? m_count - 4'd1 : m_count + 4'd1;
                    if (mode == 2'd1) begin
                        if (!m_bdir) begin
                            if (m_pos == 7) begin m_pos = 6; m_bdir = 1'b1; end
                            else m_pos = m_pos + 1;
                        end else begin
                            if (m_pos == 0) begin m_pos = 1; m_bdir = 1'b0; end
                            else m_pos = m_pos - 1;
                        end
                    end else begin
                        m_pos = direction ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
                    end
                end
            end
        end
        e.c = m_count;
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_count", 32'(count), 32'(e.c));
            check("sb_seg", 32'(seg_out), 32'(e.s));
            check("sb_bar", 32'(bar_out), 32'(e.b));
        end
        check("sb_tick", 32'(tick), 32'(en && (m_presc == 3)));
    end

    task automatic wait_step(output int n);
        logic [3:0] c0;
        c0 = count;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (count == c0 && n < 64);
        check("step_seen", 32'(count != c0), 'h1);
    endtask

    task automatic do_load(input logic [3:0] v);
        load     = 1'b1;
        load_val = v;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    int n;
    int bounce_pos [9] = '{1, 2, 3, 4, 5, 6, 7, 6, 5};

    initial begin
        rst = 1'b1; en = 1'b0; direction = 1'b0; mode = 2'd0; load = 1'b0; load_val = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 32'(count), 'h0);
        check("reset_seg", 32'(seg_out), 'hC0);
        check("reset_bar", 32'(bar_out), 'hFF);

        // Release reset, first step
        rst = 1'b0;
        en  = 1'b1;
        wait_step(n);
        check("first_step_edges", 32'(n), 'd4);
        check("first_count", 32'(count), 'h1);
        @(posedge clk); #1;
        check("first_seg", 32'(seg_out), 'hF9);
        check("first_bar", 32'(bar_out), 'hFD);

        // Up-count wrap
        do_load(4'd0);
        for (int k = 1; k <= 16; k++) begin
            wait_step(n);
            if (k == 15) begin
                check("up15_count", 32'(count), 'hF);
                @(posedge clk); #1;
                check("up15_seg", 32'(seg_out), 'h8E);
                check("up15_bar", 32'(bar_out), 'h7F);
            end else if (k == 16) begin
                check("up16_count", 32'(count), 'h0);
                @(posedge clk); #1;
                check("up16_seg", 32'(seg_out), 'hC0);
                check("up16_bar", 32'(bar_out), 'hFE);
            end
        end

        // Down-count from 0
        direction = 1'b1;
        wait_step(n);
        check("down_count", 32'(count), 'hF);
        @(posedge clk); #1;
        check("down_seg", 32'(seg_out), 'h0E);
        check("down_bar", 32'(bar_out), 'h7F);

        // Bounce with direction toggling
        mode = 2'd1;
        do_load(4'd0);
        for (int k = 0; k < 9; k++) begin
            direction = ~direction;
            wait_step(n);
            @(posedge clk); #1;
            check("bounce_bar", 32'(bar_out), 32'(8'(~(8'd1 << bounce_pos[k]))));
        end

        // Load on a tick cycle wins over the step
        direction = 1'b0;
        mode      = 2'd0;
        do_load(4'd3);
        for (int k = 0; k < 16 && !tick; k++) @(negedge clk);
        check("tick_before_load", 32'(tick), 'h1);
        load     = 1'b1;
        load_val = 4'd9;
        @(posedge clk); #1;
        load = 1'b0;
        check("load_count", 32'(count), 'h9);
        @(posedge clk); #1;
        check("load_seg", 32'(seg_out), 'h90);
        wait_step(n);
        check("load_to_step", 32'(n + 1), 'd4);
        check("load_next_count", 32'(count), 'hA);
        @(posedge clk); #1;
        check("load_next_seg", 32'(seg_out), 'h88);

        // Fill mode then reset mid-prescale
        mode = 2'd2;
        do_load(4'd3);
        @(posedge clk); #1;
        check("fill_bar", 32'(bar_out), 'hF0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_count", 32'(count), 'h0);
        check("midrst_bar", 32'(bar_out), 'hFF);
        check("midrst_seg", 32'(seg_out), 'hC0);
        wait_step(n);
        check("midrst_step_edges", 32'(n), 'd4);
        check("midrst_next_count", 32'(count), 'h1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
